// File: rtl/uart_word_streamer.sv
// UART word transmitter: buffers multi-byte words in a FIFO and serialises each
// as back-to-back 8N1 frames, optionally preceded by a sync header byte.
module uart_word_streamer #(
  parameter int          CLK_FREQ   = 200_000_000,
  parameter int          BAUD_RATE  = 9600,
  parameter int          WORD_BYTES = 4,
  parameter int          FIFO_DEPTH = 8,
  parameter int          MSB_FIRST  = 0,
  parameter int          SYNC_EN    = 0,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [8*WORD_BYTES-1:0]       in_data,
  input  logic                          clr_overflow,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [15:0]                   words_sent
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int NB  = WORD_BYTES + ((SYNC_EN != 0) ? 1 : 0);
  localparam int BW  = $clog2(NB + 1);
  localparam int WW  = 8 * WORD_BYTES;

  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);
  localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [BW-1:0]   byte_q, byte_d;
  logic [WW-1:0]   word_q, word_d;
  logic            tx_q, tx_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     sent_q, sent_d;
  logic [WW-1:0]   mem_q [FIFO_DEPTH];
  logic            push, pop, baud_done;
  logic [7:0]      cur_byte;

  // Slot k of the on-line sequence: the header (if enabled) maps to no data byte.
  function automatic logic [7:0] sel_byte(input logic [WW-1:0] w, input logic [BW-1:0] k);
    int         pos;
    logic [7:0] b;
    b   = SYNC_BYTE;
    pos = int'(k) - ((SYNC_EN != 0) ? 1 : 0);
    if (MSB_FIRST != 0) pos = WORD_BYTES - 1 - pos;
    for (int i = 0; i < WORD_BYTES; i++)
      if (i == pos) b = w[8*i +: 8];
    return b;
  endfunction

  assign in_ready  = (count_q != FULL);
  assign push      = in_valid && in_ready;
  assign baud_done = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    word_d   = word_q;
    sent_d   = sent_q;
    pop      = 1'b0;
    cur_byte = 8'h00;
    tx_d     = 1'b1;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          word_d  = mem_q[rd_ptr_q];
          byte_d  = '0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        baud_d = baud_q + 1'b1;
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_q + 1'b1;
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 1'b1;
        end
      end
      STOP: begin
        baud_d = baud_q + 1'b1;
        if (baud_done) begin
          baud_d = '0;
          if (byte_q != BYTE_LAST) begin
            byte_d  = byte_q + 1'b1;
            state_d = START;
          end else begin
            sent_d = sent_q + 16'd1;
            // Next queued word starts on this same edge so the line stays gapless.
            if (count_q != '0) begin
              pop     = 1'b1;
              word_d  = mem_q[rd_ptr_q];
              byte_d  = '0;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    cur_byte = sel_byte(word_d, byte_d);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    ovf_d = ovf_q;
    if (in_valid && !in_ready) ovf_d = 1'b1;
    else if (clr_overflow)     ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      sent_q   <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      sent_q   <= sent_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
    word_q <= word_d;
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign words_sent = sent_q;

endmodule

// File: doc/uart_word_streamer.md
# uart_word_streamer

Parametrised UART word transmitter for streaming generator output, such as MT19937 random numbers, to a host. It accepts words of `WORD_BYTES` bytes through a valid/ready handshake and buffers them in a `FIFO_DEPTH`-entry FIFO. Each word is serialised as consecutive 8N1 frames, with a configurable byte order and an optional sync header byte. The block contains its own baud generator and serialiser, replaces the per-design byte-sequencing FSM plus `uart_tx` pair, and runs entirely in the system clock domain.

## Interface

- `CLK_FREQ`, 200_000_000, clock frequency in Hz
- `BAUD_RATE`, 9600, line rate; bit period `DIV = CLK_FREQ / BAUD_RATE` (integer truncation, DIV ≥ 2)
- `WORD_BYTES`, 4, bytes per word, range 1..8
- `FIFO_DEPTH`, 8, word entries; power of two, ≥ 2
- `MSB_FIRST`, 0, 0 sends byte 0 (bits 7:0) first; 1 sends the top byte first
- `SYNC_EN`, 0, 1 prepends `SYNC_BYTE` before each word
- `SYNC_BYTE`, 8'hA5, header value
- `clk` in 1: system clock
- `rst` in 1: reset, synchronous and active-high
- `in_valid` in 1: word offered
- `in_ready` out 1: FIFO not full
- `in_data` in 8*WORD_BYTES: word
- `clr_overflow` in 1: clears `overflow`
- `tx` out 1: serial line, idles high
- `busy` out 1: serialiser not IDLE, or FIFO non-empty
- `fifo_count` out $clog2(FIFO_DEPTH)+1: stored words
- `overflow` out 1: sticky; set when `in_valid` is asserted while `in_ready` is low
- `words_sent` out 16: completed-word counter, wraps at 16'hFFFF→0

## Operation

- **Push:** a word is accepted on an edge with `in_valid && in_ready`. `in_ready` is `fifo_count != FIFO_DEPTH` (pre-pop value). There is no same-cycle bypass.
- **Simultaneous push and pop:** `fifo_count` is unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- **Overflow:** `overflow` is set on any edge with `in_valid && !in_ready`, and the word is dropped. `clr_overflow` clears it. If set and clear occur on the same edge, set wins.
- **State machine:** IDLE, START, DATA, STOP.
  - IDLE: if `fifo_count > 0`, pop the head into the word register, set byte index 0, select the first byte, go to START.
  - START: `tx = 0` for DIV cycles, then go to DATA.
  - DATA: 8 bits, LSB first, DIV cycles each, then go to STOP.
  - STOP: `tx = 1` for DIV cycles. Then:
    - If more bytes remain in the word, advance the byte index and go directly to START with no idle gap.
    - Else, increment `words_sent`. If the FIFO is non-empty, pop the next word and go to START on the same edge (gapless). Otherwise go to IDLE.
- **Byte sequence per word:** optional `SYNC_BYTE`, then `WORD_BYTES` data bytes.
  - `MSB_FIRST = 0`: bytes 0..N-1.
  - `MSB_FIRST = 1`: bytes N-1..0.
- **Frame length:** each word occupies `(WORD_BYTES + SYNC_EN) * 10 * DIV` cycles.
- **Baud counter:** counts 0..DIV-1 and is reloaded to 0 at every state or bit transition.
- **Output register:** `tx` is registered and glitch-free.

## Timing

- **Reset values:** `tx = 1`, `in_ready = 1`, `busy = 0`, `fifo_count = 0`, `overflow = 0`, `words_sent = 0`. The state machine is in IDLE and the FIFO pointers are 0.
- **Reset mid-operation:** any partial frame is abandoned. `tx` is 1 from the next edge and the FIFO is flushed.
- **Latency:** for a word accepted at edge E0 with the FIFO empty and the state IDLE:
  - E1: pop; `tx` goes to 0 after E1.
  - The first start bit then lasts DIV cycles.
- **`fifo_count` update:** the count reflects a push or pop one edge after it occurs. With an idle serialiser, a single word is visible as `fifo_count = 1` for exactly one cycle.
- **`words_sent` update:** increments on the edge that ends the final stop bit. `busy` falls on the same edge if the FIFO is empty.
- **Holding off:** `in_valid` may be held high indefinitely. `in_data` is sampled only on the accept edge.

## Test plan

Benches use `CLK_FREQ = 16`, `BAUD_RATE = 1` (DIV = 16), `WORD_BYTES = 4`, `FIFO_DEPTH = 8`.

1. **Single word, LSB byte order:** push 32'h0BADBEEF with `MSB_FIRST = 0` → line decodes EF, BE, AD, 0B. `tx` is low one cycle after accept. The frame lasts 640 cycles, then `words_sent = 1` and `busy = 0`.
2. **MSB order with sync header:** `MSB_FIRST = 1`, `SYNC_EN = 1`, push 32'h0BADBEEF → A5, 0B, AD, BE, EF in 800 contiguous cycles.
3. **Back-to-back words:** push 32'h11223344 and 32'h55667788 on consecutive cycles → 8 frames with no idle cycle between stop and start bits, 1280 cycles total, `words_sent = 2`.
4. **Fill and overflow:** hold `in_valid` with 10 distinct words.
   - 9 are accepted (1 popped, 8 stored), then `in_ready = 0` with `fifo_count = 8`.
   - `in_valid` asserted while `in_ready = 0` → `overflow = 1`. After `clr_overflow` → `overflow = 0`.
   - All 9 accepted words are transmitted in order.
5. **Reset mid-frame:** assert `rst` during the data bits of byte 2 with 3 words queued → `tx = 1`, `fifo_count = 0`, `busy = 0`, `words_sent = 0` next edge. A subsequent push of 32'hDEADBEEF transmits EF BE AD DE cleanly.
